// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the sender-to-aggregator fetch arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH  = 11;
    localparam int DEF_FETCH_WIDTH = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first asserted req at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int c;

    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter granting one sender FIFO for a FETCH_WIDTH-beat burst into the aggregator.
// Latency: one cycle request-to-grant, then combinational mux; one IDLE bubble between bursts.
// Backpressure: agg_deq gates sender_deq; an empty granted sender stalls the burst indefinitely.
module fetch_arbiter
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int NUM_SENDERS = 2,
    parameter int ID_WIDTH    = $clog2(NUM_SENDERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SENDERS*DATA_WIDTH-1:0] sender_data,
    input  logic [NUM_SENDERS-1:0]            sender_empty_n,
    output logic [NUM_SENDERS-1:0]            sender_deq,
    output logic [DATA_WIDTH-1:0]             agg_data,
    output logic                              agg_empty_n,
    input  logic                              agg_deq,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic                              busy,
    output logic                              tag_valid,
    output logic [ID_WIDTH-1:0]               tag_id
);

    localparam int                CW      = $clog2(FETCH_WIDTH + 1);
    localparam logic [CW-1:0]       LAST    = CW'(FETCH_WIDTH - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SENDERS - 1);

    state_t                  state;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [CW-1:0]           beat_cnt;
    logic                    pick_any;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic                    in_burst;
    logic                    beat;
    logic                    last_beat;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_SENDERS];

    for (genvar i = 0; i < NUM_SENDERS; i++) begin : g_unpack
        assign data_arr[i] = sender_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N  (NUM_SENDERS),
        .IW (ID_WIDTH)
    ) u_rr_pick (
        .req (sender_empty_n),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign in_burst = (state == BURST);

    always_comb begin
        agg_data    = '0;
        agg_empty_n = 1'b0;
        if (in_burst) begin
            agg_data    = data_arr[grant_id];
            agg_empty_n = sender_empty_n[grant_id];
        end
    end

    // A deq against an empty mux output is not a beat and must not reach the FIFO.
    assign beat      = in_burst & agg_deq & agg_empty_n;
    assign last_beat = beat && (beat_cnt == LAST);

    always_comb begin
        sender_deq           = '0;
        sender_deq[grant_id] = beat;
    end

    assign tag_valid = last_beat;
    assign tag_id    = last_beat ? grant_id : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
